sram_stream_loader: RTL and testbench
=====================================

Name: sram_stream_loader

Overview:
- Byte-stream to word-write engine on the second (s2) port of the dual-port on-chip SRAM (2048 x 32, byte-enabled).
- Accepts a ready/valid 8-bit stream, for example from the UART/move-parser path, and packs it little-endian into 32-bit words.
- Writes each word to consecutive SRAM addresses starting at a programmed base, while the Nios keeps port s1.
- Reports completion, word count and address wrap.

Parameters:
- ADDR_W, 11, SRAM word-address width; the address counter wraps modulo 2^ADDR_W.
- DATA_W, 32, SRAM data width; fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cfg_base  in  ADDR_W  first word address; sampled on accepted cfg_start.
- cfg_start  in  1  1-cycle start pulse; honoured only in IDLE.
- abort  in  1  cancel in-flight transfer.
- in_data  in  8  stream byte.
- in_valid  in  1  byte valid.
- in_last  in  1  marks the final byte of a transfer; qualified by in_valid.
- in_ready  out  1  loader can accept a byte.
- address2  out  ADDR_W  SRAM port-2 word address.
- byteenable2  out  4  SRAM port-2 byte lanes.
- chipselect2  out  1  SRAM port-2 select.
- write2  out  1  SRAM port-2 write strobe.
- writedata2  out  32  SRAM port-2 write data.
- clken2  out  1  SRAM port-2 clock enable; tied to 1 while out of reset.
- busy  out  1  high in any state except IDLE.
- done  out  1  1-cycle pulse at transfer completion.
- word_count  out  ADDR_W+1  words written in the current/last transfer.
- wrapped  out  1  sticky; set when the address wraps past 2^ADDR_W-1; cleared on accepted cfg_start.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; in_ready=0; chipselect2=0; write2=0; byteenable2=0; writedata2=0; address2=0; busy=0; done=0; word_count=0; wrapped=0; clken2=0. Any partial word is discarded. Reset mid-transfer issues no write.
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - On cfg_start: addr<=cfg_base, lane<=0, be<=0, word_count<=0, wrapped<=0, go to FILL.
- FILL:
  - in_ready=1. A byte is accepted when in_valid&in_ready.
  - Accepted byte goes to writedata2[8*lane+7:8*lane], be[lane]<=1, lane<=lane+1.
  - If lane==3, or in_last is set on the accepted byte, go to WRITE next cycle; remember last_seen=in_last.
  - Bytes not yet filled keep stale data with byteenable=0.
- WRITE (exactly 1 cycle):
  - in_ready=0; chipselect2=1; write2=1; byteenable2=be; address2=addr.
  - The SRAM has no waitrequest, so the write completes this cycle.
  - Next cycle: word_count+1; be<=0; lane<=0.
  - Address update: addr<=addr+1. If addr was 2^ADDR_W-1, addr<=0 and wrapped<=1.
  - Next state: DONE if last_seen, else FILL.
- Write throughput: at most one write per 5 cycles (4 accepts + 1 write). Stream stalls are allowed at any point in FILL.
- DONE: done=1 for 1 cycle, then IDLE.
- address2 holds addr in all states; chipselect2/write2 are high only in WRITE.
- abort:
  - In FILL or DONE: go to IDLE next cycle; discard the partial word; no write; no done pulse.
  - In WRITE: the current write completes, then go to IDLE; no done pulse.
  - In IDLE: ignored.
- cfg_start while busy: ignored. abort and cfg_start together in IDLE: start wins.
- word_count saturates at 2^ADDR_W. Wrapping writes overwrite earlier data; this is not an error.

Optional Feature:
- Macro SRAM_STREAM_LOADER_CHECKSUM_EN.
- Defined: adds output checksum[31:0].
  - Cleared on accepted cfg_start.
  - In each WRITE cycle: checksum <= checksum + (writedata2 masked by byteenable2, lanes with be=0 counted as 0), mod 2^32.
  - Valid when done pulses.
- Undefined: port and logic absent.

Test Plan:
- Start cfg_base=0x010, stream 8 bytes 01..08 with last on 08 -> writes addr 0x010 data 0x04030201 be=F, addr 0x011 data 0x08070605 be=F; done 1 cycle after second write; word_count=2.
- Start base=0x020, stream 5 bytes AA BB CC DD EE (last on EE) -> addr 0x020 0xDDCCBBAA be=F; addr 0x021 lane0=0xEE be=0x1; word_count=2.
- Start base=0x7FF, 8 bytes -> writes at 0x7FF then 0x000; wrapped=1 after the first write; word_count=2.
- Random in_valid gaps plus abort asserted after 3 bytes of a word -> no write2 pulse, no done, busy=0 next cycle; next cfg_start works normally.
- Assert reset_n=0 in the WRITE cycle after two completed words -> all outputs 0 next edge; cfg_start pulsed during busy -> ignored (base unchanged).
- With SRAM_STREAM_LOADER_CHECKSUM_EN defined: bytes 01..05 last -> checksum = 0x04030201 + 0x00000005 = 0x04030206 at done.

Source files
------------

// File: rtl/sram_stream_loader.sv
// Packs a ready/valid byte stream little-endian into 32-bit SRAM port-2 writes: one write 1 cycle after the word's last byte, done 1 cycle later.
// Stream stalls only during WRITE/DONE/IDLE. Define SRAM_STREAM_LOADER_CHECKSUM_EN to add the byte-masked write checksum output.
module sram_stream_loader #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic              cfg_start,
   input  logic              abort,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [ADDR_W-1:0] address2,
   output logic [3:0]        byteenable2,
   output logic              chipselect2,
   output logic              write2,
   output logic [DATA_W-1:0] writedata2,
   output logic              clken2,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   word_count,
   output logic              wrapped
`ifdef SRAM_STREAM_LOADER_CHECKSUM_EN
   ,
   output logic [31:0]       checksum
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

   localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_lane;
   logic [3:0]        r_be;
   logic              r_last;
   logic [DATA_W-1:0] r_wdata;
   logic [ADDR_W:0]   r_count;
   logic              r_wrapped;
   logic              r_clken;
   logic              w_accept;

   assign w_accept = in_valid && (r_state == S_FILL);

`ifdef SRAM_STREAM_LOADER_CHECKSUM_EN
   logic [31:0] r_checksum;
   logic [31:0] w_masked;

   // Lanes left stale by a short final word contribute zero.
   always_comb begin
      w_masked = '0;
      for (int i = 0; i < 4; i++) begin
         if (r_be[i]) w_masked[8*i +: 8] = r_wdata[8*i +: 8];
      end
   end

   assign checksum = r_checksum;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_lane    <= '0;
         r_be      <= '0;
         r_last    <= 1'b0;
         r_wdata   <= '0;
         r_count   <= '0;
         r_wrapped <= 1'b0;
         r_clken   <= 1'b0;
`ifdef SRAM_STREAM_LOADER_CHECKSUM_EN
         r_checksum <= '0;
`endif
      end else begin
         r_clken <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (cfg_start) begin
                  r_addr    <= cfg_base;
                  r_lane    <= '0;
                  r_be      <= '0;
                  r_last    <= 1'b0;
                  r_count   <= '0;
                  r_wrapped <= 1'b0;
`ifdef SRAM_STREAM_LOADER_CHECKSUM_EN
                  r_checksum <= '0;
`endif
                  r_state   <= S_FILL;
               end
            end
            S_FILL: begin
               if (abort) begin
                  r_be    <= '0;
                  r_lane  <= '0;
                  r_state <= S_IDLE;
               end else if (w_accept) begin
                  r_wdata[{r_lane, 3'b000} +: 8] <= in_data;
                  r_be[r_lane] <= 1'b1;
                  r_lane       <= r_lane + 2'd1;
                  if (r_lane == 2'd3 || in_last) begin
                     r_last  <= in_last;
                     r_state <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               // The SRAM has no waitrequest, so the write always lands this cycle, even under abort.
               r_be   <= '0;
               r_lane <= '0;
               r_addr <= r_addr + 1'b1;
               if (&r_addr) r_wrapped <= 1'b1;
               if (r_count != COUNT_MAX) r_count <= r_count + 1'b1;
`ifdef SRAM_STREAM_LOADER_CHECKSUM_EN
               r_checksum <= r_checksum + w_masked;
`endif
               if (abort)       r_state <= S_IDLE;
               else if (r_last) r_state <= S_DONE;
               else             r_state <= S_FILL;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready    = (r_state == S_FILL);
   assign chipselect2 = (r_state == S_WRITE);
   assign write2      = (r_state == S_WRITE);
   assign byteenable2 = (r_state == S_WRITE) ? r_be : 4'b0000;
   assign address2    = r_addr;
   assign writedata2  = r_wdata;
   assign clken2      = r_clken;
   assign busy        = (r_state != S_IDLE);
   // An abort in the DONE cycle suppresses the completion pulse.
   assign done        = (r_state == S_DONE) && !abort;
   assign word_count  = r_count;
   assign wrapped     = r_wrapped;

endmodule

// File: tb/tb_sram_stream_loader.sv
// Randomized bench for sram_stream_loader: writes are captured by a monitor and compared with a byte-list model.
`timescale 1ns/1ps
module tb_sram_stream_loader;
   localparam int ADDR_W = 11;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [ADDR_W-1:0] cfg_base;
   logic              cfg_start;
   logic              abort;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;
   logic [ADDR_W-1:0] address2;
   logic [3:0]        byteenable2;
   logic              chipselect2;
   logic              write2;
   logic [31:0]       writedata2;
   logic              clken2;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   word_count;
   logic              wrapped;
`ifdef SRAM_STREAM_LOADER_CHECKSUM_EN
   logic [31:0]       checksum;
`endif

   sram_stream_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_base(cfg_base), .cfg_start(cfg_start),
      .abort(abort), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .address2(address2), .byteenable2(byteenable2),
      .chipselect2(chipselect2), .write2(write2), .writedata2(writedata2),
      .clken2(clken2), .busy(busy), .done(done), .word_count(word_count),
      .wrapped(wrapped)
`ifdef SRAM_STREAM_LOADER_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Write/done monitor, sampled on the falling edge.
   logic [ADDR_W-1:0] wq_addr[$];
   logic [3:0]        wq_be[$];
   logic [31:0]       wq_data[$];
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_wr_cyc = 0;
   logic [7:0] stim_q[$];

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (write2 && chipselect2) begin
         wq_addr.push_back(address2);
         wq_be.push_back(byteenable2);
         wq_data.push_back(writedata2 & lane_mask(byteenable2));
         last_wr_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic start(input logic [ADDR_W-1:0] base);
      @(negedge clk);
      cfg_base  = base;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] d, input logic l, input int gapmax);
      int g = 0;
      repeat ($urandom_range(gapmax, 0)) begin
         in_data = 8'($urandom);
         @(negedge clk);
      end
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      while (!in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) begin
         checks++;
         $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, expected 1", g);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int g = 0;
      while (busy && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (busy) begin
         checks++;
         $display("FAIL %s idle_timeout: busy=1 after %0d cycles, expected 0", name, g);
      end
   endtask

   // Model: bytes of stim_q grouped in fours, word w at (base+w) mod DEPTH.
   task automatic check_transfer(input string name, input int base, input int w0,
                                 input int d0, input bit each);
      int n     = stim_q.size();
      int words = (n + 3) / 4;
      int got   = wq_addr.size() - w0;
      int exp_cnt;
      logic [31:0] sum = '0;
      checks++;
      if (got !== words) $display("FAIL %s write_count: got %0d, expected %0d", name, got, words);
      else passed++;
      for (int w = 0; w < words; w++) begin
         int nb;
         logic [31:0] ed;
         logic [3:0] eb;
         logic [ADDR_W-1:0] ea;
         nb = (n - 4*w >= 4) ? 4 : n - 4*w;
         ed = '0;
         for (int k = 0; k < nb; k++) ed = ed | (32'(stim_q[4*w+k]) << (8*k));
         eb = 4'((1 << nb) - 1);
         ea = ADDR_W'((base + w) % DEPTH);
         sum = sum + ed;
         if (each && w < got) begin
            checks++;
            if (wq_addr[w0+w] !== ea || wq_be[w0+w] !== eb || wq_data[w0+w] !== ed)
               $display("FAIL %s word%0d: addr %h be %h data %h, expected addr %h be %h data %h",
                        name, w, wq_addr[w0+w], wq_be[w0+w], wq_data[w0+w], ea, eb, ed);
            else passed++;
         end
      end
      checks++;
      if (done_cnt - d0 !== 1) $display("FAIL %s done_pulses: got %0d, expected 1", name, done_cnt - d0);
      else passed++;
      checks++;
      if (done_cyc !== last_wr_cyc + 1)
         $display("FAIL %s done_timing: done at cycle %0d, expected %0d", name, done_cyc, last_wr_cyc + 1);
      else passed++;
      exp_cnt = (words > DEPTH) ? DEPTH : words;
      checks++;
      if (word_count !== (ADDR_W+1)'(exp_cnt))
         $display("FAIL %s word_count: got %0d, expected %0d", name, word_count, exp_cnt);
      else passed++;
      checks++;
      if (wrapped !== (base + words >= DEPTH))
         $display("FAIL %s wrapped: got %0b, expected %0b", name, wrapped, (base + words >= DEPTH));
      else passed++;
`ifdef SRAM_STREAM_LOADER_CHECKSUM_EN
      checks++;
      if (checksum !== sum) $display("FAIL %s checksum: got %h, expected %h", name, checksum, sum);
      else passed++;
`endif
   endtask

   task automatic do_transfer(input string name, input int base, input int gapmax, input bit each);
      int w0 = wq_addr.size();
      int d0 = done_cnt;
      start(ADDR_W'(base));
      for (int i = 0; i < stim_q.size(); i++)
         push_byte(stim_q[i], (i == stim_q.size() - 1), gapmax);
      wait_idle(name);
      check_transfer(name, base, w0, d0, each);
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({in_ready, chipselect2, write2, byteenable2, busy, done, clken2, wrapped} !== '0)
         $display("FAIL %s ctrl: in_ready %b cs %b wr %b be %h busy %b done %b clken %b wrapped %b, expected all 0",
                  name, in_ready, chipselect2, write2, byteenable2, busy, done, clken2, wrapped);
      else passed++;
      checks++;
      if ({address2, writedata2, word_count} !== '0)
         $display("FAIL %s data: addr %h data %h count %0d, expected 0", name, address2, writedata2, word_count);
      else passed++;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; cfg_base = '0; cfg_start = 1'b0; abort = 1'b0;
      in_data = '0; in_valid = 1'b0; in_last = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (clken2 !== 1'b1 || busy !== 1'b0) $display("FAIL reset_release: clken2 %b busy %b, expected 1 0", clken2, busy);
      else passed++;
   endtask

   task automatic test_basic();
      stim_q.delete();
      for (int i = 1; i <= 8; i++) stim_q.push_back(8'(i));
      do_transfer("basic", 'h010, 0, 1'b1);
   endtask

   task automatic test_partial();
      stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      do_transfer("partial", 'h020, 2, 1'b1);
   endtask

   task automatic test_wrap();
      int w0 = wq_addr.size();
      int d0 = done_cnt;
      stim_q.delete();
      for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom));
      start(11'h7FF);
      for (int i = 0; i < 4; i++) push_byte(stim_q[i], 1'b0, 1);
      checks++;
      if (wrapped !== 1'b0) $display("FAIL wrap_before: wrapped %b, expected 0", wrapped);
      else passed++;
      @(negedge clk);
      checks++;
      if (wrapped !== 1'b1 || address2 !== '0)
         $display("FAIL wrap_after: wrapped %b addr %h, expected 1 000", wrapped, address2);
      else passed++;
      for (int i = 4; i < 8; i++) push_byte(stim_q[i], (i == 7), 1);
      wait_idle("wrap");
      check_transfer("wrap", 'h7FF, w0, d0, 1'b1);
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         int base = (t % 3 == 0) ? DEPTH - 1 - int'($urandom_range(2, 0)) : int'($urandom_range(DEPTH - 1, 0));
         int n = $urandom_range(13, 1);
         stim_q.delete();
         for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
         do_transfer("random", base, 3, 1'b1);
      end
   endtask

   task automatic test_abort_fill();
      int w0 = wq_addr.size();
      int d0 = done_cnt;
      start(11'h123);
      for (int i = 0; i < 3; i++) push_byte(8'($urandom), 1'b0, 3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) $display("FAIL abort_fill_busy: busy %b, expected 0", busy);
      else passed++;
      repeat (4) @(negedge clk);
      checks++;
      if (wq_addr.size() != w0 || done_cnt != d0)
         $display("FAIL abort_fill_quiet: writes %0d dones %0d, expected 0 0", wq_addr.size() - w0, done_cnt - d0);
      else passed++;
      stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      do_transfer("after_abort", 'h200, 2, 1'b1);
   endtask

   task automatic test_abort_write();
      int w0 = wq_addr.size();
      int d0 = done_cnt;
      start(11'h300);
      for (int i = 0; i < 4; i++) push_byte(8'($urandom), 1'b0, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || word_count !== 12'd1 || address2 !== 11'h301)
         $display("FAIL abort_write_state: busy %b count %0d addr %h, expected 0 1 301", busy, word_count, address2);
      else passed++;
      checks++;
      if (wq_addr.size() - w0 != 1 || done_cnt != d0)
         $display("FAIL abort_write_pulses: writes %0d dones %0d, expected 1 0", wq_addr.size() - w0, done_cnt - d0);
      else passed++;
   endtask

   task automatic test_start_while_busy();
      int w0 = wq_addr.size();
      int d0 = done_cnt;
      stim_q.delete();
      for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom));
      start(11'h100);
      push_byte(stim_q[0], 1'b0, 0);
      push_byte(stim_q[1], 1'b0, 0);
      cfg_base  = 11'h300;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      for (int i = 2; i < 8; i++) push_byte(stim_q[i], (i == 7), 0);
      wait_idle("start_busy");
      check_transfer("start_busy", 'h100, w0, d0, 1'b1);
   endtask

   task automatic test_reset_mid();
      start(11'h050);
      for (int i = 0; i < 12; i++) push_byte(8'($urandom), 1'b0, 1);
      checks++;
      if (write2 !== 1'b1) $display("FAIL reset_mid_write: write2 %b, expected 1", write2);
      else passed++;
      reset_n = 1'b0;
      @(negedge clk);
      check_all_zero("reset_mid");
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (clken2 !== 1'b1 || busy !== 1'b0) $display("FAIL reset_mid_release: clken2 %b busy %b, expected 1 0", clken2, busy);
      else passed++;
      stim_q = '{8'h5A, 8'hA5, 8'h3C};
      do_transfer("after_reset", 'h060, 1, 1'b1);
   endtask

   task automatic test_saturate();
      stim_q.delete();
      for (int i = 0; i < (DEPTH + 1) * 4; i++) stim_q.push_back(8'($urandom));
      do_transfer("saturate", 0, 0, 1'b0);
   endtask

`ifdef SRAM_STREAM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      do_transfer("checksum_xfer", 'h040, 1, 1'b1);
      checks++;
      if (checksum !== 32'h04030206) $display("FAIL checksum_const: got %h, expected 04030206", checksum);
      else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_partial();
      test_wrap();
      test_random();
      test_abort_fill();
      test_abort_write();
      test_start_while_busy();
      test_reset_mid();
      test_saturate();
`ifdef SRAM_STREAM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
